// File: rtl/bit_reduction_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_reduction_sequencer_if
// Purpose  : Beat-input and result-output handshake bundle for the sequencer.
// Revision : 1.0
// ============================================================================
interface bit_reduction_sequencer_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) ();
    logic [2:0]             op_in;
    logic [WORD_WIDTH-1:0]  word_in;
    logic                   word_last;
    logic                   word_valid;
    logic                   word_ready;
    logic                   result_bit;
    logic [COUNT_WIDTH-1:0] result_count;
    logic                   result_error;
    logic                   result_valid;
    logic                   result_ready;
    logic                   busy;

    modport slave (
        input  op_in, word_in, word_last, word_valid, result_ready,
        output word_ready, result_bit, result_count, result_error,
               result_valid, busy
    );

    modport master (
        output op_in, word_in, word_last, word_valid, result_ready,
        input  word_ready, result_bit, result_count, result_error,
               result_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_reduction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bit_reduction_sequencer
// Purpose  : Reduces every bit of a multi-beat message to one AND/OR/XOR
//            (optionally inverted) result bit, with a saturating beat count.
// Revision : 1.0
// ============================================================================
module bit_reduction_sequencer #(
    parameter int WORD_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    bit_reduction_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // op[2:1] selects the base operator; op[0] selects inversion
    localparam logic [1:0] c_base_and = 2'b00;
    localparam logic [1:0] c_base_or  = 2'b01;
    localparam logic [1:0] c_base_xor = 2'b10;
    localparam logic [COUNT_WIDTH-1:0] c_count_max = {COUNT_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic                   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   res_bit_q, res_bit_d;
    logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
    logic                   res_err_q, res_err_d;

    logic       w_ready;
    logic       w_accept;
    logic [2:0] w_op;
    logic       w_beat;
    logic       w_merged;
    logic       w_illegal;

    assign w_ready  = (state_q != S_HOLD);
    assign w_accept = bus.word_valid & w_ready;

    // The first beat of a message uses op_in directly; later beats use the latched op
    assign w_op = (state_q == S_IDLE) ? bus.op_in : op_q;

    always_comb begin
        w_beat = ^bus.word_in;
        case (w_op[2:1])
            c_base_and: w_beat = &bus.word_in;
            c_base_or:  w_beat = |bus.word_in;
            c_base_xor: w_beat = ^bus.word_in;
            default:    w_beat = ^bus.word_in;
        endcase
    end

    always_comb begin
        w_merged = acc_q ^ w_beat;
        case (op_q[2:1])
            c_base_and: w_merged = acc_q & w_beat;
            c_base_or:  w_merged = acc_q | w_beat;
            c_base_xor: w_merged = acc_q ^ w_beat;
            default:    w_merged = acc_q ^ w_beat;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        count_d     = count_q;
        res_bit_d   = res_bit_q;
        res_count_d = res_count_q;
        res_err_d   = res_err_q;
        w_illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = bus.op_in;
                    acc_d   = w_beat;
                    count_d = COUNT_WIDTH'(1);
                    state_d = bus.word_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    acc_d = w_merged;
                    if (count_q != c_count_max) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    if (bus.word_last) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Capture the result on the edge that accepts the last beat
        if (w_accept && bus.word_last) begin
            w_illegal   = op_d[2] & op_d[1];
            res_bit_d   = w_illegal ? 1'b0 : (acc_d ^ op_d[0]);
            res_count_d = count_d;
            res_err_d   = w_illegal;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            acc_q       <= 1'b0;
            count_q     <= '0;
            res_bit_q   <= 1'b0;
            res_count_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            res_bit_q   <= res_bit_d;
            res_count_q <= res_count_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.word_ready   = w_ready;
    assign bus.result_valid = (state_q == S_HOLD);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_bit   = res_bit_q;
    assign bus.result_count = res_count_q;
    assign bus.result_error = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_reduction_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_reduction_sequencer
// Purpose  : Self-checking bench; one wide-count and one 2-bit-count instance
//            share the same stimulus and are compared against a popcount model.
// Revision : 1.0
// ============================================================================
module tb_bit_reduction_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] op_in = 3'd0;
    logic [7:0] word_in = 8'd0;
    logic       word_last = 1'b0;
    logic       word_valid = 1'b0;
    logic       result_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] beat_w  [16];
    logic [2:0] beat_op [16];

    bit_reduction_sequencer_if #(.WORD_WIDTH(8), .COUNT_WIDTH(16)) if_a ();
    bit_reduction_sequencer_if #(.WORD_WIDTH(8), .COUNT_WIDTH(2))  if_b ();

    assign if_a.op_in = op_in;       assign if_b.op_in = op_in;
    assign if_a.word_in = word_in;   assign if_b.word_in = word_in;
    assign if_a.word_last = word_last;   assign if_b.word_last = word_last;
    assign if_a.word_valid = word_valid; assign if_b.word_valid = word_valid;
    assign if_a.result_ready = result_ready; assign if_b.result_ready = result_ready;

    bit_reduction_sequencer #(.WORD_WIDTH(8), .COUNT_WIDTH(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(if_a.slave));
    bit_reduction_sequencer #(.WORD_WIDTH(8), .COUNT_WIDTH(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(if_b.slave));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the whole message is one long bit vector; reduce it directly
    function automatic logic model_bit(input logic [2:0] op, input int ones, input int n);
        logic b;
        case (op)
            3'd0, 3'd1: b = (ones == 8 * n);
            3'd2, 3'd3: b = (ones != 0);
            3'd4, 3'd5: b = ones[0];
            default:    return 1'b0;
        endcase
        return (op == 3'd1 || op == 3'd3 || op == 3'd5) ? ~b : b;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid_a"}, 32'(if_a.result_valid), 0);
        chk({tag, "_valid_b"}, 32'(if_b.result_valid), 0);
        chk({tag, "_wready_a"}, 32'(if_a.word_ready), 1);
        chk({tag, "_wready_b"}, 32'(if_b.word_ready), 1);
        chk({tag, "_busy_a"}, 32'(if_a.busy), 0);
    endtask

    task automatic check_hold(input string tag, input logic eb, input logic ee, input int n);
        chk({tag, "_valid_a"}, 32'(if_a.result_valid), 1);
        chk({tag, "_bit_a"}, 32'(if_a.result_bit), 32'(eb));
        chk({tag, "_count_a"}, 32'(if_a.result_count), (n > 65535) ? 65535 : n);
        chk({tag, "_err_a"}, 32'(if_a.result_error), 32'(ee));
        chk({tag, "_wready_a"}, 32'(if_a.word_ready), 0);
        chk({tag, "_busy_a"}, 32'(if_a.busy), 1);
        chk({tag, "_valid_b"}, 32'(if_b.result_valid), 1);
        chk({tag, "_bit_b"}, 32'(if_b.result_bit), 32'(eb));
        chk({tag, "_count_b"}, 32'(if_b.result_count), (n > 3) ? 3 : n);
        chk({tag, "_err_b"}, 32'(if_b.result_error), 32'(ee));
    endtask

    task automatic drive_beat(input string tag, input logic [7:0] w, input logic [2:0] op,
                              input logic last, input int gap);
        repeat (gap) begin
            word_valid = 1'b0;
            op_in      = 3'($urandom_range(0, 7));
            word_in    = 8'($urandom_range(0, 255));
            @(posedge clock); #1;
        end
        word_valid = 1'b1;
        word_in    = w;
        op_in      = op;
        word_last  = last;
        chk({tag, "_beat_wready_a"}, 32'(if_a.word_ready), 1);
        chk({tag, "_beat_wready_b"}, 32'(if_b.word_ready), 1);
        @(posedge clock); #1;
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic run_msg(input string tag, input int n, input int gap_max, input int hold_cycles);
        int   ones;
        logic eb, ee;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            drive_beat(tag, beat_w[i], beat_op[i], (i == n - 1),
                       (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
            ones += $countones(beat_w[i]);
            if (i < n - 1) begin
                chk({tag, "_accum_busy"}, 32'(if_a.busy), 1);
                chk({tag, "_accum_valid"}, 32'(if_a.result_valid), 0);
            end
        end
        eb = model_bit(beat_op[0], ones, n);
        ee = (beat_op[0] >= 3'd6);
        // Offer junk beats during HOLD; they must not be consumed
        word_valid = 1'b1;
        word_last  = 1'b1;
        word_in    = 8'($urandom_range(0, 255));
        op_in      = 3'($urandom_range(0, 7));
        repeat (hold_cycles) begin
            check_hold(tag, eb, ee, n);
            @(posedge clock); #1;
        end
        check_hold(tag, eb, ee, n);
        result_ready = 1'b1;
        @(posedge clock); #1;
        result_ready = 1'b0;
        word_valid   = 1'b0;
        word_last    = 1'b0;
        check_idle({tag, "_after"});
    endtask

    initial begin
        #1;
        check_idle("reset");
        chk("reset_bit", 32'(if_a.result_bit), 0);
        chk("reset_count", 32'(if_a.result_count), 0);
        chk("reset_err", 32'(if_a.result_error), 0);
        #11 reset_n = 1'b1;
        @(posedge clock); #1;

        // XOR 01,03,07 : popcount 6 -> 0
        beat_w[0] = 8'h01; beat_w[1] = 8'h03; beat_w[2] = 8'h07;
        beat_op[0] = 3'd4; beat_op[1] = 3'd4; beat_op[2] = 3'd4;
        run_msg("xor3", 3, 0, 0);

        beat_w[0] = 8'hFF; beat_op[0] = 3'd0;
        run_msg("and1", 1, 0, 0);
        beat_op[0] = 3'd1;
        run_msg("nand1", 1, 0, 0);

        beat_w[0] = 8'h00; beat_w[1] = 8'h00; beat_w[2] = 8'h10;
        beat_op[0] = 3'd3; beat_op[1] = 3'd3; beat_op[2] = 3'd3;
        run_msg("nor3", 3, 0, 5);

        beat_w[0] = 8'h00; beat_w[1] = 8'h01;
        beat_op[0] = 3'd2; beat_op[1] = 3'd0;
        run_msg("oplatch", 2, 0, 0);

        beat_w[0] = 8'hAA; beat_w[1] = 8'h55;
        beat_op[0] = 3'd6; beat_op[1] = 3'd6;
        run_msg("illegal", 2, 0, 1);

        // Reset after two of four beats, mid-cycle
        drive_beat("rst_mid", 8'h12, 3'd4, 1'b0, 0);
        drive_beat("rst_mid", 8'h34, 3'd4, 1'b0, 0);
        word_valid = 1'b1; word_in = 8'h56;
        #2 reset_n = 1'b0;
        #1;
        check_idle("rst_mid");
        chk("rst_mid_bit", 32'(if_a.result_bit), 0);
        chk("rst_mid_count", 32'(if_a.result_count), 0);
        chk("rst_mid_err", 32'(if_a.result_error), 0);
        word_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        beat_w[0] = 8'h00; beat_op[0] = 3'd2;
        run_msg("post_rst_or", 1, 0, 0);

        for (int i = 0; i < 5; i++) begin
            beat_w[i] = 8'h01; beat_op[i] = 3'd4;
        end
        run_msg("sat_xor5", 5, 0, 0);

        for (int m = 0; m < 40; m++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       beat_w[i] = 8'h00;
                    1:       beat_w[i] = 8'hFF;
                    2:       beat_w[i] = 8'(1 << $urandom_range(0, 7));
                    default: beat_w[i] = 8'($urandom_range(0, 255));
                endcase
                beat_op[i] = 3'($urandom_range(0, 7));
            end
            run_msg("rand", n, 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
